// File: rtl/program_pkg.sv
// Shared types and default sizing for the program loader.
package program_pkg;

    localparam int DEF_ADDR_W    = 11;
    localparam int DEF_DATA_W    = 16;
    localparam int DEF_MAX_WORDS = 512;

    typedef enum logic [3:0] {
        IDLE,
        LEN_HI,
        LEN_LO,
        DAT_HI,
        DAT_LO,
        WRITE,
        CK_HI,
        CK_LO,
        DONE,
        ERROR
    } state_t;

    function automatic logic is_rx_state(state_t s);
        return s inside {LEN_HI, LEN_LO, DAT_HI, DAT_LO, CK_HI, CK_LO};
    endfunction

    function automatic logic is_busy_state(state_t s);
        return !(s inside {IDLE, DONE, ERROR});
    endfunction

endpackage

// File: rtl/program_loader_if.sv
// Byte stream in / memory write port out of the program loader.
interface program_loader_if import program_pkg::*; #(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) ();

    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;

    modport master (
        output rx_data, rx_valid,
        input  rx_ready, mem_addr, mem_wdata, mem_we
    );

    modport slave (
        input  rx_data, rx_valid,
        output rx_ready, mem_addr, mem_wdata, mem_we
    );

endinterface

// File: rtl/program_loader_byte_assembler.sv
// Packs a high byte and a following low byte into one word; word_valid pulses
// the cycle after the low byte is taken.
module byte_assembler import program_pkg::*; #(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              hi_en,
    input  logic              lo_en,
    input  logic [7:0]        byte_in,
    output logic [DATA_W-1:0] word_next,
    output logic [DATA_W-1:0] word,
    output logic              word_valid
);

    logic [7:0]        hi_q, hi_d;
    logic [DATA_W-1:0] word_q, word_d;
    logic              valid_q, valid_d;

    always_comb begin
        word_next = DATA_W'({hi_q, byte_in});
        hi_d      = hi_q;
        word_d    = word_q;
        valid_d   = lo_en;
        if (hi_en) hi_d = byte_in;
        if (lo_en) word_d = word_next;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            hi_q    <= '0;
            word_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            hi_q    <= hi_d;
            word_q  <= word_d;
            valid_q <= valid_d;
        end
    end

    assign word       = word_q;
    assign word_valid = valid_q;

endmodule

// File: rtl/program_loader.sv
// Loads a length-prefixed word stream from a byte channel into program memory.
// Optional feature: LOADER_CHECKSUM_EN adds a trailing checksum word check.
module program_loader import program_pkg::*; #(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int MAX_WORDS = DEF_MAX_WORDS
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic              abort,
    program_loader_if.slave   bus,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   word_count
);

    state_t              state_q, state_d;
    logic [ADDR_W:0]     word_count_q, word_count_d;
    logic [DATA_W-1:0]   len_q, len_d;
`ifdef LOADER_CHECKSUM_EN
    logic [DATA_W-1:0]   sum_q, sum_d;
`endif

    logic                accept;
    logic                hi_en;
    logic                lo_en;
    logic                write_fire;
    logic [DATA_W-1:0]   asm_next;
    logic [DATA_W-1:0]   asm_word;
    logic                asm_valid;

    assign accept = bus.rx_valid && is_rx_state(state_q);
    assign hi_en  = accept && (state_q inside {LEN_HI, DAT_HI, CK_HI});
    assign lo_en  = accept && (state_q inside {LEN_LO, DAT_LO, CK_LO});

    byte_assembler #(
        .DATA_W (DATA_W)
    ) u_asm (
        .clock      (clock),
        .reset_n    (reset_n),
        .hi_en      (hi_en),
        .lo_en      (lo_en),
        .byte_in    (bus.rx_data),
        .word_next  (asm_next),
        .word       (asm_word),
        .word_valid (asm_valid)
    );

    // Abort suppresses the strobe even in the WRITE cycle itself.
    assign write_fire    = (state_q == WRITE) && asm_valid && !abort;
    assign bus.mem_we    = write_fire;
    assign bus.mem_addr  = write_fire ? word_count_q[ADDR_W-1:0] : '0;
    assign bus.mem_wdata = write_fire ? asm_word : '0;
    assign bus.rx_ready  = is_rx_state(state_q);
    assign busy          = is_busy_state(state_q);
    assign done          = (state_q == DONE);
    assign error         = (state_q == ERROR);
    assign word_count    = word_count_q;

    always_comb begin
        state_d      = state_q;
        word_count_d = word_count_q;
        len_d        = len_q;
`ifdef LOADER_CHECKSUM_EN
        sum_d        = sum_q;
`endif
        case (state_q)
            IDLE, DONE, ERROR: begin
                if (start) begin
                    state_d      = LEN_HI;
                    word_count_d = '0;
`ifdef LOADER_CHECKSUM_EN
                    sum_d        = '0;
`endif
                end
            end
            LEN_HI: if (accept) state_d = LEN_LO;
            LEN_LO: begin
                if (accept) begin
                    len_d = asm_next;
                    if (asm_next == '0 || 32'(asm_next) > 32'(MAX_WORDS))
                        state_d = ERROR;
                    else
                        state_d = DAT_HI;
                end
            end
            DAT_HI: if (accept) state_d = DAT_LO;
            DAT_LO: if (accept) state_d = WRITE;
            WRITE: begin
                word_count_d = word_count_q + (ADDR_W+1)'(1);
`ifdef LOADER_CHECKSUM_EN
                sum_d        = sum_q + asm_word;
`endif
                if (32'(word_count_q) + 32'd1 < 32'(len_q))
                    state_d = DAT_HI;
                else
`ifdef LOADER_CHECKSUM_EN
                    state_d = CK_HI;
`else
                    state_d = DONE;
`endif
            end
`ifdef LOADER_CHECKSUM_EN
            CK_HI: if (accept) state_d = CK_LO;
            CK_LO: begin
                if (accept) state_d = (asm_next == sum_q) ? DONE : ERROR;
            end
`endif
            default: state_d = IDLE;
        endcase

        // Abort discards any same-cycle progress, including the count/sum update.
        if (abort && is_busy_state(state_q)) begin
            state_d      = IDLE;
            word_count_d = word_count_q;
            len_d        = len_q;
`ifdef LOADER_CHECKSUM_EN
            sum_d        = sum_q;
`endif
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            word_count_q <= '0;
            len_q        <= '0;
`ifdef LOADER_CHECKSUM_EN
            sum_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            word_count_q <= word_count_d;
            len_q        <= len_d;
`ifdef LOADER_CHECKSUM_EN
            sum_q        <= sum_d;
`endif
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader; handles builds with and without
// LOADER_CHECKSUM_EN.
module tb_program_loader;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        start;
    logic        abort;
    logic        busy;
    logic        done;
    logic        error;
    logic [11:0] word_count;

    int tests = 0;
    int fails = 0;
    int base;

    logic [10:0] wa[$];
    logic [15:0] wd[$];

    program_loader_if #(.ADDR_W(11), .DATA_W(16)) bus ();

    program_loader #(
        .ADDR_W    (11),
        .DATA_W    (16),
        .MAX_WORDS (512)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .start      (start),
        .abort      (abort),
        .bus        (bus),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .word_count (word_count)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (bus.mem_we === 1'b1) begin
            wa.push_back(bus.mem_addr);
            wd.push_back(bus.mem_wdata);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        assert (act === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, act, exp);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        if (gap > 0) begin
            repeat (gap) @(negedge clock);
            check("rx_ready_held", bus.rx_ready, 1);
        end
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        n = 0;
        while (bus.rx_ready !== 1'b1 && n < 50) begin
            @(negedge clock);
            n++;
        end
        check("rx_accept", bus.rx_ready, 1);
        @(negedge clock);
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
    endtask

    task automatic finish_load(input int gap, input logic [7:0] ck_lo);
`ifdef LOADER_CHECKSUM_EN
        send_byte(8'hBE, gap);
        send_byte(ck_lo, gap);
`else
        if (ck_lo != 8'h00) @(negedge clock);
        else @(negedge clock);
`endif
    endtask

    initial begin
        reset_n      = 1'b0;
        start        = 1'b0;
        abort        = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        repeat (2) @(negedge clock);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        check("rst_rx_ready", bus.rx_ready, 0);
        check("rst_mem_we", bus.mem_we, 0);
        check("rst_word_count", word_count, 0);
        reset_n = 1'b1;
        @(negedge clock);

        // Basic two-word load
        pulse_start();
        check("t1_busy", busy, 1);
        check("t1_rx_ready", bus.rx_ready, 1);
        send_byte(8'h00, 0);
        send_byte(8'h02, 0);
        send_byte(8'h12, 0);
        send_byte(8'h34, 0);
        check("t1_we0", bus.mem_we, 1);
        check("t1_addr0", bus.mem_addr, 0);
        check("t1_data0", bus.mem_wdata, 16'h1234);
        check("t1_wc_in_write0", word_count, 0);
        send_byte(8'hAB, 0);
        send_byte(8'hCD, 0);
        check("t1_we1", bus.mem_we, 1);
        check("t1_addr1", bus.mem_addr, 1);
        check("t1_data1", bus.mem_wdata, 16'hABCD);
        check("t1_wc_in_write1", word_count, 1);
        finish_load(0, 8'h01);
        check("t1_done", done, 1);
        check("t1_busy_end", busy, 0);
        check("t1_error", error, 0);
        check("t1_word_count", word_count, 2);
        check("t1_we_idle", bus.mem_we, 0);
        check("t1_nwrites", wa.size(), 2);
        check("t1_wa0", wa[0], 0);
        check("t1_wd0", wd[0], 16'h1234);
        check("t1_wa1", wa[1], 1);
        check("t1_wd1", wd[1], 16'hABCD);

        // Zero length
        pulse_start();
        check("t2_done_cleared", done, 0);
        check("t2_wc_cleared", word_count, 0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        check("t2_len0_error", error, 1);
        check("t2_len0_busy", busy, 0);
        check("t2_len0_nwrites", wa.size(), 2);

        // Length one past the limit
        pulse_start();
        check("t2_error_cleared", error, 0);
        send_byte(8'h02, 0);
        send_byte(8'h01, 0);
        check("t2_len513_error", error, 1);
        check("t2_len513_nwrites", wa.size(), 2);

        // Gaps of five idle cycles between bytes
        pulse_start();
        send_byte(8'h00, 5);
        send_byte(8'h02, 5);
        send_byte(8'h12, 5);
        send_byte(8'h34, 5);
        check("t3_data0", bus.mem_wdata, 16'h1234);
        send_byte(8'hAB, 5);
        send_byte(8'hCD, 5);
        check("t3_addr1", bus.mem_addr, 1);
        finish_load(5, 8'h01);
        check("t3_done", done, 1);
        check("t3_word_count", word_count, 2);
        check("t3_nwrites", wa.size(), 4);
        check("t3_wa2", wa[2], 0);
        check("t3_wd2", wd[2], 16'h1234);
        check("t3_wa3", wa[3], 1);
        check("t3_wd3", wd[3], 16'hABCD);

        // Abort while the low data byte arrives
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h02, 0);
        send_byte(8'h12, 0);
        abort        = 1'b1;
        bus.rx_valid = 1'b1;
        bus.rx_data  = 8'h34;
        @(negedge clock);
        abort        = 1'b0;
        bus.rx_valid = 1'b0;
        check("t4_busy", busy, 0);
        check("t4_rx_ready", bus.rx_ready, 0);
        check("t4_done", done, 0);
        check("t4_error", error, 0);
        repeat (5) @(negedge clock);
        check("t4_nwrites", wa.size(), 4);

`ifdef LOADER_CHECKSUM_EN
        // Checksum mismatch
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h02, 0);
        send_byte(8'h12, 0);
        send_byte(8'h34, 0);
        send_byte(8'hAB, 0);
        send_byte(8'hCD, 0);
        send_byte(8'hBE, 0);
        send_byte(8'h02, 0);
        check("t5_ck_error", error, 1);
        check("t5_ck_done", done, 0);
        check("t5_nwrites", wa.size(), 6);
`endif

        // Reset in DAT_LO, then a clean reload
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h02, 0);
        send_byte(8'h12, 0);
        send_byte(8'h34, 0);
        send_byte(8'hAB, 0);
        base = wa.size();
        reset_n = 1'b0;
        #1;
        check("t6_busy", busy, 0);
        check("t6_done", done, 0);
        check("t6_error", error, 0);
        check("t6_rx_ready", bus.rx_ready, 0);
        check("t6_mem_we", bus.mem_we, 0);
        check("t6_mem_addr", bus.mem_addr, 0);
        check("t6_mem_wdata", bus.mem_wdata, 0);
        check("t6_word_count", word_count, 0);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        check("t6_no_write", wa.size(), base);
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h02, 0);
        send_byte(8'h12, 0);
        send_byte(8'h34, 0);
        send_byte(8'hAB, 0);
        send_byte(8'hCD, 0);
        finish_load(0, 8'h01);
        check("t6_done_after", done, 1);
        check("t6_nwrites", wa.size(), base + 2);
        check("t6_wa0", wa[base], 0);
        check("t6_wd0", wd[base], 16'h1234);
        check("t6_wa1", wa[base+1], 1);
        check("t6_wd1", wd[base+1], 16'hABCD);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
